sgdmac_axi_mem: RTL and testbench
=================================

# sgdmac_axi_mem

AXI3-subset responder (slave) with an internal word-addressed SRAM, answering the AW/W/B and AR/R channels that the SG-DMA controller issues as initiator. It serves as the memory endpoint in block-level and top-level DMA simulation and holds descriptors and source/destination buffers. Reads and writes run as independent state machines, each with one outstanding burst, over a dual-port array.

## Interface
- MEM_DEPTH_LOG2, 12: log2 of SRAM depth in 32-bit words (default 16 KiB).
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- awid_i / awaddr_i / awlen_i / awsize_i / awburst_i  input  4/32/4/3/2  write address channel
- awvalid_i  input  1;  awready_o  output  1
- wid_i / wdata_i / wstrb_i / wlast_i  input  4/32/4/1  write data channel
- wvalid_i  input  1;  wready_o  output  1
- bid_o / bresp_o  output  4/2;  bvalid_o  output  1;  bready_i  input  1
- arid_i / araddr_i / arlen_i / arsize_i / arburst_i  input  4/32/4/3/2  read address channel
- arvalid_i  input  1;  arready_o  output  1
- rid_o / rdata_o / rresp_o / rlast_o  output  4/32/2/1;  rvalid_o  output  1;  rready_i  input  1

## Operation
- Write FSM: W_IDLE (awready_o=1) -> AW handshake latches id, addr, len, burst, error flag -> W_DATA (wready_o=1) -> beat accepted when wvalid_i&&wready_o -> W_RESP (bvalid_o=1) -> B handshake -> W_IDLE.
- Each write beat updates bytes whose wstrb_i bit is set at word addr[MEM_DEPTH_LOG2+1:2]; INCR (2'b01) adds 4 per beat; FIXED (2'b00) holds address; WRAP treated as INCR.
- Beat counter 4 bits; W_DATA exits on the beat with counter==len, regardless of wlast_i.
- bresp_o=2'b10 (SLVERR) if: addr[31:MEM_DEPTH_LOG2+2]!=0 (that beat's write suppressed), awsize!=3'b010, or wlast_i disagrees with counter==len on any beat. Otherwise 2'b00. bid_o=latched awid.
- Read FSM: R_IDLE (arready_o=1) -> AR handshake -> R_DATA. rdata_o registered from array; rlast_o=1 on beat counter==arlen; after rlast handshake -> R_IDLE.
- rresp_o=2'b10 with rdata_o=32'h0 on out-of-range beats or arsize!=3'b010; else 2'b00. rid_o=latched arid.
- Address increment wraps modulo 2^32; in-range bursts crossing top of array become out-of-range, never alias.
- Same-cycle read and write to one word: read returns old data.
- wid_i ignored (single outstanding write).

## Timing
- Reset values: awready_o=0, wready_o=0, bvalid_o=0, bresp_o=0, bid_o=0, arready_o=0, rvalid_o=0, rdata_o=0, rresp_o=0, rlast_o=0, rid_o=0; FSMs to IDLE; ready outputs go to 1 the cycle after rst_n deasserts. SRAM contents are not reset.
- AW handshake cycle N -> wready_o=1 at N+1. Last W beat at M -> bvalid_o=1 at M+1. B handshake at K -> awready_o=1 at K+1.
- AR handshake cycle N -> first rvalid_o at N+1; one beat per cycle while rready_i=1; R outputs held stable while rvalid_o&&!rready_i. Last beat handshake at K -> arready_o=1 at K+1.
- bvalid_o/rvalid_o never deassert before handshake. Reset mid-burst aborts immediately; no response is issued for the aborted burst.

## Configuration
- SGDMAC_AXI_MEM_STALL_EN defined: 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 at reset, advances every cycle) gates awready_o, wready_o, arready_o (low when lfsr[0]=0) and delays rvalid_o/bvalid_o assertion (not deassertion) while lfsr[1]=0. Rules in Timing become minimum latencies.
- Undefined: zero-wait behaviour exactly as in Timing.

## Test plan
- Preload word 0x40 = 32'h1234_5678; AR addr 0x100, len 0, size 2 -> one R beat, rdata 32'h1234_5678, rlast 1, rresp 0, rvalid at handshake+1.
- AW addr 0x200, len 3, INCR; W data 1..4, wstrb 4'hF, wlast on beat 4 -> bresp 0, bid echoed; AR same burst returns 1,2,3,4, rlast on beat 4 only.
- Write 32'hAABB_CCDD with wstrb 4'b0101 over 32'h0 -> readback 32'h00BB_00DD.
- AW addr 0x0001_0000 (out of range, default depth) -> bresp 2'b10, array unchanged; AR same address -> rresp 2'b10, rdata 0.
- wlast asserted on beat 2 of len 3 burst -> bresp 2'b10; rready_i held low 5 cycles mid-read -> rdata/rlast stable throughout.
- rst_n low during W_DATA beat 2 -> all outputs at reset values next cycle, no B response; next burst completes normally.

Source files
------------

// File: rtl/sgdmac_axi_mem_if.sv
// AXI3-subset AW/W/B and AR/R channel bundle between the SG-DMA initiator and the memory responder.
interface sgdmac_axi_mem_if;
    logic [3:0]  awid_i;
    logic [31:0] awaddr_i;
    logic [3:0]  awlen_i;
    logic [2:0]  awsize_i;
    logic [1:0]  awburst_i;
    logic        awvalid_i;
    logic        awready_o;
    logic [3:0]  wid_i;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic        wlast_i;
    logic        wvalid_i;
    logic        wready_o;
    logic [3:0]  bid_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i;
    logic [3:0]  arid_i;
    logic [31:0] araddr_i;
    logic [3:0]  arlen_i;
    logic [2:0]  arsize_i;
    logic [1:0]  arburst_i;
    logic        arvalid_i;
    logic        arready_o;
    logic [3:0]  rid_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rlast_o;
    logic        rvalid_o;
    logic        rready_i;

    modport slave (
        input  awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i,
        input  wid_i, wdata_i, wstrb_i, wlast_i, wvalid_i, bready_i,
        input  arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i, rready_i,
        output awready_o, wready_o, bid_o, bresp_o, bvalid_o,
        output arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
    );

    modport master (
        output awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i,
        output wid_i, wdata_i, wstrb_i, wlast_i, wvalid_i, bready_i,
        output arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i, rready_i,
        input  awready_o, wready_o, bid_o, bresp_o, bvalid_o,
        input  arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
    );
endinterface

// File: rtl/sgdmac_axi_mem.sv
// AXI3-subset memory responder: independent single-outstanding read/write FSMs over a word SRAM.
// Optional random back-pressure when SGDMAC_AXI_MEM_STALL_EN is defined.
module sgdmac_axi_mem #(
    parameter int MEM_DEPTH_LOG2 = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    sgdmac_axi_mem_if.slave   axi
);
    localparam int AW    = MEM_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [31:0] r_mem [DEPTH];

    // Ready outputs stay low until the first cycle after reset is released.
    logic r_live;
    always_ff @(posedge clk) begin
        if (!rst_n) r_live <= 1'b0;
        else        r_live <= 1'b1;
    end

    logic w_stall_rdy, w_stall_vld;
`ifdef SGDMAC_AXI_MEM_STALL_EN
    logic [7:0] r_lfsr;
    always_ff @(posedge clk) begin
        if (!rst_n) r_lfsr <= 8'hA5;
        else        r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
    assign w_stall_rdy = r_lfsr[0];
    assign w_stall_vld = r_lfsr[1];
`else
    assign w_stall_rdy = 1'b1;
    assign w_stall_vld = 1'b1;
`endif

    // ---------------- write side ----------------
    wstate_t     r_ws, w_ws_nxt;
    logic [3:0]  r_wid, r_wlen, r_wcnt;
    logic [31:0] r_waddr;
    logic [1:0]  r_wburst;
    logic        r_werr, r_bv_hold;
    logic        w_awready, w_wready, w_bvalid;
    logic        w_aw_hs, w_w_hs, w_b_hs, w_wlast_beat, w_w_oor;

    assign w_aw_hs      = axi.awvalid_i && w_awready;
    assign w_w_hs       = axi.wvalid_i && w_wready;
    assign w_b_hs       = w_bvalid && axi.bready_i;
    assign w_wlast_beat = (r_wcnt == r_wlen);
    assign w_w_oor      = (r_waddr[31:AW+2] != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) r_ws <= W_IDLE;
        else        r_ws <= w_ws_nxt;
    end

    always_comb begin
        w_ws_nxt = r_ws;
        case (r_ws)
            W_IDLE:  if (w_aw_hs) w_ws_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_wlast_beat) w_ws_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_ws_nxt = W_IDLE;
            default: w_ws_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_awready = r_live && (r_ws == W_IDLE) && w_stall_rdy;
        w_wready  = r_live && (r_ws == W_DATA) && w_stall_rdy;
        w_bvalid  = (r_ws == W_RESP) && (w_stall_vld || r_bv_hold);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wid     <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
            r_waddr   <= '0;
            r_wburst  <= '0;
            r_werr    <= 1'b0;
            r_bv_hold <= 1'b0;
        end else begin
            r_bv_hold <= w_bvalid && !axi.bready_i;
            if (w_aw_hs) begin
                r_wid    <= axi.awid_i;
                r_waddr  <= axi.awaddr_i;
                r_wlen   <= axi.awlen_i;
                r_wburst <= axi.awburst_i;
                r_wcnt   <= '0;
                r_werr   <= (axi.awsize_i != 3'b010);
            end else if (w_w_hs) begin
                r_wcnt <= r_wcnt + 4'd1;
                if (r_wburst != 2'b00) r_waddr <= r_waddr + 32'd4;
                if (w_w_oor || (axi.wlast_i != w_wlast_beat)) r_werr <= 1'b1;
            end
        end
    end

    // SRAM is not reset; a beat landing in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && w_w_hs && !w_w_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (axi.wstrb_i[b]) r_mem[r_waddr[AW+1:2]][8*b +: 8] <= axi.wdata_i[8*b +: 8];
            end
        end
    end

    assign axi.awready_o = w_awready;
    assign axi.wready_o  = w_wready;
    assign axi.bvalid_o  = w_bvalid;
    assign axi.bid_o     = r_wid;
    assign axi.bresp_o   = r_werr ? 2'b10 : 2'b00;

    // ---------------- read side ----------------
    rstate_t     r_rs, w_rs_nxt;
    logic [3:0]  r_rid, r_rlen, r_rcnt;
    logic [31:0] r_raddr, r_rdata;
    logic [1:0]  r_rburst, r_rresp;
    logic        r_rsz_err, r_rlast, r_rv_hold;
    logic        w_arready, w_rvalid, w_ar_hs, w_r_hs, w_rd_load, w_rd_err;
    logic [31:0] w_raddr_nxt, w_rd_addr;

    assign w_ar_hs     = axi.arvalid_i && w_arready;
    assign w_r_hs      = w_rvalid && axi.rready_i;
    assign w_raddr_nxt = (r_rburst != 2'b00) ? r_raddr + 32'd4 : r_raddr;
    // The next beat is fetched on the handshake of the current one so rdata_o is always registered.
    assign w_rd_addr   = w_ar_hs ? axi.araddr_i : w_raddr_nxt;
    assign w_rd_err    = (w_rd_addr[31:AW+2] != '0) ||
                         (w_ar_hs ? (axi.arsize_i != 3'b010) : r_rsz_err);
    assign w_rd_load   = w_ar_hs || (w_r_hs && !r_rlast);

    always_ff @(posedge clk) begin
        if (!rst_n) r_rs <= R_IDLE;
        else        r_rs <= w_rs_nxt;
    end

    always_comb begin
        w_rs_nxt = r_rs;
        case (r_rs)
            R_IDLE:  if (w_ar_hs) w_rs_nxt = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast) w_rs_nxt = R_IDLE;
            default: w_rs_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_arready = r_live && (r_rs == R_IDLE) && w_stall_rdy;
        w_rvalid  = (r_rs == R_DATA) && (w_stall_vld || r_rv_hold);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rid     <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_raddr   <= '0;
            r_rburst  <= '0;
            r_rsz_err <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= '0;
            r_rv_hold <= 1'b0;
        end else begin
            r_rv_hold <= w_rvalid && !axi.rready_i;
            if (w_ar_hs) begin
                r_rid     <= axi.arid_i;
                r_rlen    <= axi.arlen_i;
                r_rburst  <= axi.arburst_i;
                r_rsz_err <= (axi.arsize_i != 3'b010);
                r_rcnt    <= '0;
                r_raddr   <= axi.araddr_i;
                r_rlast   <= (axi.arlen_i == 4'd0);
            end else if (w_r_hs && !r_rlast) begin
                r_rcnt  <= r_rcnt + 4'd1;
                r_raddr <= w_raddr_nxt;
                r_rlast <= ((r_rcnt + 4'd1) == r_rlen);
            end
            if (w_rd_load) begin
                r_rdata <= w_rd_err ? 32'h0 : r_mem[w_rd_addr[AW+1:2]];
                r_rresp <= w_rd_err ? 2'b10 : 2'b00;
            end
        end
    end

    assign axi.arready_o = w_arready;
    assign axi.rvalid_o  = w_rvalid;
    assign axi.rid_o     = r_rid;
    assign axi.rdata_o   = r_rdata;
    assign axi.rresp_o   = r_rresp;
    assign axi.rlast_o   = r_rlast;

    logic w_unused;
    assign w_unused = ^axi.wid_i;
endmodule

// File: tb/tb_sgdmac_axi_mem.sv
// Scoreboard bench for sgdmac_axi_mem: a byte-level memory model predicts B and R responses.
module tb_sgdmac_axi_mem;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sgdmac_axi_mem_if axi();
    sgdmac_axi_mem #(.MEM_DEPTH_LOG2(12)) dut (.clk(clk), .rst_n(rst_n), .axi(axi));

    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

    rbeat_t      exp_r[$];
    bexp_t       exp_b[$];
    logic [31:0] model [int unsigned];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [49:0] all_outs();
        return {axi.awready_o, axi.wready_o, axi.bvalid_o, axi.bresp_o, axi.bid_o,
                axi.arready_o, axi.rvalid_o, axi.rdata_o, axi.rresp_o, axi.rlast_o, axi.rid_o};
    endfunction

    task automatic init_inputs();
        axi.awid_i = 0; axi.awaddr_i = 0; axi.awlen_i = 0; axi.awsize_i = 3'b010; axi.awburst_i = 2'b01;
        axi.awvalid_i = 0; axi.wid_i = 0; axi.wdata_i = 0; axi.wstrb_i = 0; axi.wlast_i = 0;
        axi.wvalid_i = 0; axi.bready_i = 0; axi.arid_i = 0; axi.araddr_i = 0; axi.arlen_i = 0;
        axi.arsize_i = 3'b010; axi.arburst_i = 2'b01; axi.arvalid_i = 0; axi.rready_i = 0;
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input logic [31:0] dbase,
                             input logic [3:0] strb, input int wlast_beat);
        logic [31:0] a, w;
        logic        err;
        bexp_t       eb;
        int          cyc;
        a = addr;
        err = (size != 3'b010);
        for (int i = 0; i <= int'(len); i++) begin
            if (a[31:14] != 0) err = 1'b1;
            else begin
                w = model.exists(int'(a[13:2])) ? model[int'(a[13:2])] : 32'h0;
                for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = (dbase + i) >> (8*b);
                model[int'(a[13:2])] = w;
            end
            if ((i == wlast_beat) != (i == int'(len))) err = 1'b1;
            if (burst != 2'b00) a = a + 32'd4;
        end
        eb.id = id; eb.resp = err ? 2'b10 : 2'b00;
        exp_b.push_back(eb);

        axi.awid_i = id; axi.awaddr_i = addr; axi.awlen_i = len; axi.awburst_i = burst;
        axi.awsize_i = size; axi.awvalid_i = 1;
        cyc = 0;
        while (axi.awready_o !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        if (cyc >= 100) begin n_cmp++; n_err++; $display("FAIL aw_timeout: awready never high, want 1"); end
        @(negedge clk);
        axi.awvalid_i = 0;
        n_cmp++;
        if (axi.wready_o !== 1'b1) begin n_err++; $display("FAIL aw_to_w: wready=%b want 1", axi.wready_o); end
        for (int i = 0; i <= int'(len); i++) begin
            axi.wvalid_i = 1; axi.wdata_i = dbase + i; axi.wstrb_i = strb; axi.wlast_i = (i == wlast_beat);
            cyc = 0;
            while (axi.wready_o !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
            if (cyc >= 100) begin n_cmp++; n_err++; $display("FAIL w_timeout: wready never high beat %0d", i); end
            @(negedge clk);
        end
        axi.wvalid_i = 0; axi.wlast_i = 0;
        n_cmp++;
        if (axi.bvalid_o !== 1'b1) begin n_err++; $display("FAIL w_to_b: bvalid=%b want 1", axi.bvalid_o); end
        eb = exp_b.pop_front();
        n_cmp++;
        if ({axi.bid_o, axi.bresp_o} !== {eb.id, eb.resp})
        begin n_err++; $display("FAIL bresp: id/resp=%h/%b want %h/%b", axi.bid_o, axi.bresp_o, eb.id, eb.resp); end
        axi.bready_i = 1;
        @(negedge clk);
        axi.bready_i = 0;
        n_cmp++;
        if (axi.awready_o !== 1'b1 || axi.bvalid_o !== 1'b0)
        begin n_err++; $display("FAIL b_to_aw: awready=%b bvalid=%b want 1/0", axi.awready_o, axi.bvalid_o); end
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input int hold_beat);
        logic [31:0] a;
        logic        err;
        rbeat_t      e;
        int          cyc;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            err = (a[31:14] != 0) || (size != 3'b010);
            e.data = err ? 32'h0 : (model.exists(int'(a[13:2])) ? model[int'(a[13:2])] : 32'h0);
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (i == int'(len));
            exp_r.push_back(e);
            a = a + 32'd4;
        end
        axi.arid_i = id; axi.araddr_i = addr; axi.arlen_i = len; axi.arsize_i = size;
        axi.arburst_i = 2'b01; axi.arvalid_i = 1;
        cyc = 0;
        while (axi.arready_o !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        if (cyc >= 100) begin n_cmp++; n_err++; $display("FAIL ar_timeout: arready never high, want 1"); end
        @(negedge clk);
        axi.arvalid_i = 0;
        n_cmp++;
        if (axi.rvalid_o !== 1'b1) begin n_err++; $display("FAIL ar_to_r: rvalid=%b want 1", axi.rvalid_o); end
        for (int i = 0; i <= int'(len); i++) begin
            cyc = 0;
            while (axi.rvalid_o !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
            if (cyc >= 100) begin n_cmp++; n_err++; $display("FAIL r_timeout: rvalid never high beat %0d", i); end
            e = exp_r.pop_front();
            n_cmp++;
            if ({axi.rid_o, axi.rdata_o, axi.rresp_o, axi.rlast_o} !== {id, e.data, e.resp, e.last})
            begin
                n_err++;
                $display("FAIL rbeat%0d: id=%h data=%h resp=%b last=%b want %h %h %b %b", i,
                         axi.rid_o, axi.rdata_o, axi.rresp_o, axi.rlast_o, id, e.data, e.resp, e.last);
            end
            if (i == hold_beat) begin
                repeat (5) begin
                    @(negedge clk);
                    n_cmp++;
                    if ({axi.rvalid_o, axi.rdata_o, axi.rlast_o, axi.rresp_o} !== {1'b1, e.data, e.last, e.resp})
                    begin
                        n_err++;
                        $display("FAIL r_hold: v=%b data=%h last=%b want 1 %h %b", axi.rvalid_o,
                                 axi.rdata_o, axi.rlast_o, e.data, e.last);
                    end
                end
            end
            axi.rready_i = 1;
            @(negedge clk);
            axi.rready_i = 0;
        end
        n_cmp++;
        if (axi.arready_o !== 1'b1 || axi.rvalid_o !== 1'b0)
        begin n_err++; $display("FAIL r_to_ar: arready=%b rvalid=%b want 1/0", axi.arready_o, axi.rvalid_o); end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (all_outs() !== 50'h0) begin n_err++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
        rst_n = 1;
        @(negedge clk);
        n_cmp++;
        if ({axi.awready_o, axi.arready_o, axi.wready_o} !== 3'b110)
        begin n_err++; $display("FAIL reset_release: aw/ar/w ready=%b%b%b want 110", axi.awready_o, axi.arready_o, axi.wready_o); end
    endtask

    task automatic test_single_read();
        axi_write(4'h1, 32'h100, 4'd0, 2'b01, 3'b010, 32'h1234_5678, 4'hF, 0);
        axi_read(4'h2, 32'h100, 4'd0, 3'b010, -1);
    endtask

    task automatic test_incr_burst();
        axi_write(4'h3, 32'h200, 4'd3, 2'b01, 3'b010, 32'd1, 4'hF, 3);
        axi_read(4'h4, 32'h200, 4'd3, 3'b010, -1);
    endtask

    task automatic test_strobe();
        axi_write(4'h5, 32'h0, 4'd0, 2'b01, 3'b010, 32'h0, 4'hF, 0);
        axi_write(4'h6, 32'h0, 4'd0, 2'b01, 3'b010, 32'hAABB_CCDD, 4'b0101, 0);
        axi_read(4'h7, 32'h0, 4'd0, 3'b010, -1);
    endtask

    task automatic test_out_of_range();
        axi_write(4'h8, 32'h0001_0000, 4'd0, 2'b01, 3'b010, 32'hDEAD_BEEF, 4'hF, 0);
        axi_read(4'h9, 32'h0001_0000, 4'd0, 3'b010, -1);
        axi_read(4'hA, 32'h0, 4'd0, 3'b010, -1);
        // Burst running off the top of the array: second beat must not alias to word 0.
        axi_write(4'hB, 32'h3FFC, 4'd1, 2'b01, 3'b010, 32'h77, 4'hF, 1);
        axi_read(4'hC, 32'h3FFC, 4'd1, 3'b010, -1);
        axi_read(4'hD, 32'h0, 4'd0, 3'b010, -1);
        axi_read(4'hE, 32'h100, 4'd0, 3'b001, -1);
        axi_write(4'hF, 32'h700, 4'd0, 2'b01, 3'b001, 32'h1, 4'hF, 0);
    endtask

    task automatic test_wlast_err_stall();
        axi_write(4'h3, 32'h280, 4'd3, 2'b01, 3'b010, 32'h50, 4'hF, 1);
        axi_read(4'h4, 32'h280, 4'd3, 3'b010, 2);
        axi_write(4'h5, 32'h600, 4'd2, 2'b00, 3'b010, 32'h90, 4'hF, 2);
        axi_read(4'h6, 32'h600, 4'd0, 3'b010, -1);
    endtask

    task automatic test_back_to_back();
        fork
            axi_write(4'h7, 32'h300, 4'd3, 2'b01, 3'b010, 32'hC0DE_0000, 4'hF, 3);
            axi_read(4'h8, 32'h200, 4'd3, 3'b010, -1);
        join
        axi_read(4'h9, 32'h300, 4'd3, 3'b010, -1);
        axi_read(4'hA, 32'h200, 4'd1, 3'b010, -1);
    endtask

    task automatic test_reset_mid_burst();
        int cyc;
        axi_write(4'h1, 32'h400, 4'd1, 2'b01, 3'b010, 32'hAAAA_0000, 4'hF, 1);
        axi.awid_i = 4'h2; axi.awaddr_i = 32'h400; axi.awlen_i = 4'd3; axi.awburst_i = 2'b01;
        axi.awsize_i = 3'b010; axi.awvalid_i = 1;
        cyc = 0;
        while (axi.awready_o !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        @(negedge clk);
        axi.awvalid_i = 0;
        axi.wvalid_i = 1; axi.wdata_i = 32'h5555_0000; axi.wstrb_i = 4'hF; axi.wlast_i = 0;
        cyc = 0;
        while (axi.wready_o !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        @(negedge clk);
        model[32'h400 >> 2] = 32'h5555_0000;
        // Beat 2 offered in the same cycle reset is asserted: it must not reach the array.
        axi.wdata_i = 32'h5555_0001;
        rst_n = 0;
        @(negedge clk);
        n_cmp++;
        if (all_outs() !== 50'h0) begin n_err++; $display("FAIL midreset_outs: got %h want 0", all_outs()); end
        rst_n = 1;
        axi.wvalid_i = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({axi.awready_o, axi.bvalid_o} !== 2'b10)
        begin n_err++; $display("FAIL midreset_nob: awready=%b bvalid=%b want 1/0", axi.awready_o, axi.bvalid_o); end
        axi_write(4'h3, 32'h500, 4'd1, 2'b01, 3'b010, 32'h600D_0000, 4'hF, 1);
        axi_read(4'h4, 32'h400, 4'd1, 3'b010, -1);
        axi_read(4'h5, 32'h500, 4'd1, 3'b010, -1);
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_single_read();
        test_incr_burst();
        test_strobe();
        test_out_of_range();
        test_wlast_err_stall();
        test_back_to_back();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
